// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 SRAM access path.
package slc3_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam logic PORT_CPU        = 1'b0;
   localparam logic PORT_LDR        = 1'b1;
   localparam int   SRAM_ADDR_W     = 20;
   localparam int   DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/slc3_rr_arb2.sv
// Two-way round-robin grant; the caller owns and updates rr_last.
module slc3_rr_arb2
   import slc3_mem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       rr_last,
   output logic       gnt_idx,
   output logic       gnt_valid
);

   always_comb begin
      gnt_valid = |req;
      gnt_idx   = PORT_CPU;
      if (req == 2'b11) begin
         gnt_idx = ~rr_last;
      end else begin
         gnt_idx = req[1];
      end
   end

endmodule

// File: rtl/slc3_sram_arbiter.sv
// Shares the off-chip async SRAM between the CPU and loader ports and
// turns a req/ack handshake into timed active-low SRAM strobes.
module slc3_sram_arbiter
   import slc3_mem_pkg::*;
#(
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter int ADDR_W      = 16
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   req0,
   input  logic                   we0,
   input  logic [ADDR_W-1:0]      addr0,
   input  logic [15:0]            wdata0,
   output logic                   ack0,
   input  logic                   req1,
   input  logic                   we1,
   input  logic [ADDR_W-1:0]      addr1,
   input  logic [15:0]            wdata1,
   output logic                   ack1,
   output logic [15:0]            rdata,
   output logic                   busy,
   output logic                   CE,
   output logic                   UB,
   output logic                   LB,
   output logic                   OE,
   output logic                   WE,
   output logic [SRAM_ADDR_W-1:0] ADDR,
   inout  wire  [15:0]            Data
);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              port_q, port_d;
   logic              rr_last_q, rr_last_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [15:0]       rdata_q, rdata_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;

   logic              gnt_idx;
   logic              gnt_valid;

   slc3_rr_arb2 u_arb (
      .req       ({req1, req0}),
      .rr_last   (rr_last_q),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      port_d    = port_q;
      rr_last_d = rr_last_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               port_d    = gnt_idx;
               rr_last_d = gnt_idx;
               we_d      = (gnt_idx == PORT_LDR) ? we1    : we0;
               addr_d    = (gnt_idx == PORT_LDR) ? addr1  : addr0;
               wdata_d   = (gnt_idx == PORT_LDR) ? wdata1 : wdata0;
               cnt_d     = 4'(WAIT_CYCLES - 1);
               state_d   = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               // Sample the bus on the last strobe cycle, while OE is still low.
               if (!we_q) begin
                  rdata_d = Data;
               end
               ack0_d  = (port_q == PORT_CPU);
               ack1_d  = (port_q == PORT_LDR);
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         port_q    <= PORT_CPU;
         rr_last_q <= PORT_LDR;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= 16'h0000;
         rdata_q   <= 16'h0000;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         port_q    <= port_d;
         rr_last_q <= rr_last_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
      end
   end

   // Strobes decode only from flops, so reset releases the bus immediately.
   assign CE    = (state_q != ACCESS);
   assign UB    = (state_q != ACCESS);
   assign LB    = (state_q != ACCESS);
   assign OE    = !((state_q == ACCESS) && !we_q);
   assign WE    = !((state_q == ACCESS) && we_q);
   assign ADDR  = {{(SRAM_ADDR_W - ADDR_W){1'b0}}, addr_q};
   assign Data  = ((state_q == ACCESS) && we_q) ? wdata_q : 16'hzzzz;
   assign rdata = rdata_q;
   assign ack0  = ack0_q;
   assign ack1  = ack1_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_slc3_sram_arbiter.sv
// Directed scoreboard bench for slc3_sram_arbiter with a small async SRAM model.
module tb_slc3_sram_arbiter;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, we0, req1, we1;
   logic [15:0] addr0, wdata0, addr1, wdata1;
   logic        ack0, ack1, busy;
   logic [15:0] rdata;
   logic        CE, UB, LB, OE, WE;
   logic [19:0] ADDR;
   wire  [15:0] sram_data;

   logic [15:0] mem [0:255];

   typedef struct packed {
      logic        port;
      logic [15:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always #10 clk = ~clk;

   slc3_sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(16)) dut (
      .Clk    (clk),
      .Reset  (rst),
      .req0   (req0),
      .we0    (we0),
      .addr0  (addr0),
      .wdata0 (wdata0),
      .ack0   (ack0),
      .req1   (req1),
      .we1    (we1),
      .addr1  (addr1),
      .wdata1 (wdata1),
      .ack1   (ack1),
      .rdata  (rdata),
      .busy   (busy),
      .CE     (CE),
      .UB     (UB),
      .LB     (LB),
      .OE     (OE),
      .WE     (WE),
      .ADDR   (ADDR),
      .Data   (sram_data)
   );

   // Async SRAM: drives when selected and output-enabled, writes while WE low.
   assign sram_data = (!CE && !OE) ? mem[ADDR[7:0]] : 16'hzzzz;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!CE && !WE && !UB && !LB && ADDR[19:8] == 12'h000) mem[ADDR[7:0]] <= sram_data;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Scoreboard monitor: every ack pops one expected response.
   always @(negedge clk) begin
      if (ack0 || ack1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack got ack0=%0b ack1=%0b want none", ack0, ack1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("ack_port", {30'd0, ack1, ack0}, mon_e.port ? 32'd2 : 32'd1);
            chk("rdata", {16'd0, rdata}, {16'd0, mon_e.rdata});
            $display("txn ack port=%0d rdata=%h expected=%h", mon_e.port, rdata, mon_e.rdata);
         end
      end
   end

   task automatic check_reset_state();
      chk("rst_ce", {31'd0, CE}, 32'd1);
      chk("rst_oe_we", {30'd0, OE, WE}, 32'd3);
      chk("rst_ub_lb", {30'd0, UB, LB}, 32'd3);
      chk("rst_addr", {12'd0, ADDR}, 32'd0);
      chk("rst_ack", {30'd0, ack1, ack0}, 32'd0);
      chk("rst_rdata", {16'd0, rdata}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
   endtask

   task automatic drive(input logic port, input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
      if (port) begin
         req1 = r; we1 = w; addr1 = a; wdata1 = d;
      end else begin
         req0 = r; we0 = w; addr0 = a; wdata0 = d;
      end
   endtask

   // Single access from an idle arbiter; exp_rd is the rdata due with the ack.
   task automatic do_access(input logic port, input logic w, input logic [15:0] a,
                            input logic [15:0] d, input logic [15:0] exp_rd);
      exp_t e;
      int   lat;
      e.port  = port;
      e.rdata = exp_rd;
      exp_q.push_back(e);
      drive(port, 1'b1, w, a, d);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (port ? ack1 : ack0) begin
            lat = k;
            break;
         end
         if (k <= W) begin
            chk("acc_ce", {31'd0, CE}, 32'd0);
            chk("acc_we", {31'd0, WE}, {31'd0, ~w});
            chk("acc_oe", {31'd0, OE}, {31'd0, w});
            chk("acc_addr", {12'd0, ADDR}, {16'd0, a});
            if (k == 1) drive(port, 1'b1, ~w, a + 16'd1, ~d);
         end
      end
      chk("latency", lat, W + 1);
      chk("done_strobes", {29'd0, CE, OE, WE}, 32'd7);
      chk("done_busy", {31'd0, busy}, 32'd1);
      drive(port, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      chk("idle_strobes", {29'd0, CE, OE, WE}, 32'd7);
      chk("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      int t [0:3];
      int idle_n;
      exp_t e;

      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (2) @(negedge clk);
      check_reset_state();
      rst = 1'b0;
      @(negedge clk);

      do_access(1'b0, 1'b1, 16'h0074, 16'h1234, 16'h0000);
      do_access(1'b0, 1'b0, 16'h0074, 16'h0000, 16'h1234);
      do_access(1'b1, 1'b1, 16'h0000, 16'hBEEF, 16'h1234);
      do_access(1'b0, 1'b0, 16'h0000, 16'h0000, 16'hBEEF);

      // Fresh reset so both ports arrive together with rr_last at its reset value.
      rst = 1'b1;
      #1;
      check_reset_state();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      e = '{port: 1'b0, rdata: 16'h1234}; exp_q.push_back(e);
      e = '{port: 1'b1, rdata: 16'hBEEF}; exp_q.push_back(e);
      e = '{port: 1'b0, rdata: 16'h1234}; exp_q.push_back(e);
      e = '{port: 1'b1, rdata: 16'hBEEF}; exp_q.push_back(e);
      drive(1'b0, 1'b1, 1'b0, 16'h0074, 16'h0000);
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
      n = 0;
      for (int k = 0; k < 40 && n < 4; k++) begin
         @(negedge clk);
         if (ack0 || ack1) begin
            t[n] = cyc;
            n++;
         end
      end
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("contend_acks", n, 4);
      chk("contend_gap01", t[1] - t[0], W + 2);
      chk("contend_gap12", t[2] - t[1], W + 2);
      chk("contend_gap23", t[3] - t[2], W + 2);
      repeat (2) @(negedge clk);

      for (int i = 0; i < 3; i++) begin
         e = '{port: 1'b0, rdata: 16'hBEEF};
         exp_q.push_back(e);
      end
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
      n = 0;
      idle_n = 0;
      for (int k = 0; k < 40 && n < 3; k++) begin
         @(negedge clk);
         if (!busy) idle_n++;
         if (ack0) begin
            t[n] = cyc;
            n++;
         end
      end
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("b2b_acks", n, 3);
      chk("b2b_gap01", t[1] - t[0], W + 2);
      chk("b2b_gap12", t[2] - t[1], W + 2);
      chk("b2b_idle_cycles", idle_n, 2);
      repeat (2) @(negedge clk);

      // Abort a write mid-access; no ack may follow.
      drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'h5555);
      @(negedge clk);
      chk("abort_in_access", {31'd0, CE}, 32'd0);
      rst = 1'b1;
      #1;
      chk("abort_strobes", {29'd0, CE, OE, WE}, 32'd7);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_ack", {30'd0, ack1, ack0}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_busy_after", {31'd0, busy}, 32'd0);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog got timeout want completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/slc3_sram_arbiter.md
Name: slc3_sram_arbiter

Overview:
- Sequences every access to the off-chip 16-bit SRAM and shares it between two requesters: port 0 is the SLC-3 CPU memory interface (MAR/MDR side), port 1 is the program loader/debug port.
- Converts a simple req/ack handshake into timed SRAM strobes on CE, UB, LB, OE and WE, drives the bidirectional Data bus, and returns read data.
- Sits in the SLC-3 top level between the slc3 core and the SRAM pins.

Parameters:
- WAIT_CYCLES, 2, SRAM strobe-active cycles per access (legal range 1..15).
- ADDR_W, 16, requester address width; zero-extended onto the 20-bit ADDR.

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-high reset
- req0  in  1  CPU access request
- we0  in  1  CPU write (1) / read (0)
- addr0  in  ADDR_W  CPU address
- wdata0  in  16  CPU write data
- ack0  out  1  one-cycle completion pulse to CPU
- req1, we1, addr1, wdata1, ack1  (same as port 0)  loader port
- rdata  out  16  read data, valid only in an ack cycle
- busy  out  1  high in every non-IDLE state
- CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active-low
- ADDR  out  20  SRAM address
- Data  inout  16  SRAM data bus

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, rr_last=1, so port 0 wins the first tie.
  - CE=OE=WE=1, UB=LB=1, ADDR=0, Data=Z.
  - ack0=ack1=0, rdata=0, busy=0.
  - Reset asserted mid-access aborts the access with no ack; the requester re-issues it.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If req0|req1 is high at the rising edge, grant one port, latch its we/addr/wdata into internal registers, load cnt=WAIT_CYCLES-1, and go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration (round robin):
  - Single requester: that port is granted.
  - Both requesting: grant the port != rr_last.
  - rr_last is updated to the granted port at grant.
- ACCESS:
  - ADDR = zero-extended latched address. CE=0, UB=LB=0.
  - Read: OE=0, WE=1, Data=Z.
  - Write: OE=1, WE=0, Data driven with the latched wdata.
  - cnt decrements each cycle. When cnt==0, a read captures Data into rdata, and the FSM goes to DONE.
- DONE:
  - All strobes return high and Data=Z. This gives one bus-turnaround cycle.
  - The ack of the granted port is 1 for exactly this cycle.
  - rdata holds the captured value; it is unchanged after a write.
  - Next state is IDLE.
- Latency: ack is seen WAIT_CYCLES+1 edges after the edge that sampled req in IDLE. Minimum access spacing is WAIT_CYCLES+2 cycles.
- Requester rules:
  - The requester holds req until it sees ack.
  - Changes to addr/we/wdata after grant are ignored because the values are latched.
  - If req is still high in the IDLE cycle after ack, that is a new access (back-to-back).
- Fairness: with both ports continuously requesting, grants strictly alternate. Neither port waits more than one other access.
- No combinational path from req to any output. All outputs are registered or decoded from registered state.
- Data is driven only in ACCESS with a write latched. There is never contention with SRAM read drive.
- rdata and ack are registered.
- busy = (state != IDLE).

Decomposition:
- Package slc3_mem_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - PORT_CPU=0 and PORT_LDR=1;
  - SRAM_ADDR_W=20 and the default WAIT_CYCLES.
- Sub-module slc3_rr_arb2: a 2-way round-robin grant.
  - Inputs: req[1:0], rr_last.
  - Outputs: gnt_idx, gnt_valid.
  - Purely combinational; the parent owns the rr_last register.

Test Plan:
- Reset mid-access: assert Reset while in ACCESS -> CE/OE/WE=1 and Data=Z within the same time step; no ack; busy=0.
- CPU write then read with WAIT_CYCLES=2:
  - req0, we0=1, addr0=16'h0074, wdata0=16'h1234 -> WE=0 and ADDR=20'h00074 for 2 cycles; ack0 on the 3rd edge.
  - Then read 16'h0074 through an SRAM model -> rdata=16'h1234 with ack0.
- Latch check: change addr0 to 16'h0075 one cycle after grant -> ADDR stays 20'h00074 for the whole access.
- Contention:
  - req0 and req1 held high continuously -> grant order is 0,1,0,1, and ack0/ack1 alternate every 4 cycles.
  - Both requests arriving first after reset -> port 0 wins.
- Loader write, CPU read:
  - req1 writes 16'hBEEF to 16'h0000, then req0 reads 16'h0000 -> rdata=16'hBEEF.
  - Data=Z in the DONE and IDLE cycles (check for no X on the bus).
- Back-to-back: req0 held high across ack0 for 3 reads -> acks spaced exactly WAIT_CYCLES+2 cycles apart; busy low for exactly 1 cycle between accesses.
